rom_loader: RTL

Upstream feeder for the synchronous ROM/RAM blocks: takes the host download byte stream (MiSTer ioctl style), filters it by download index, buffers it in a 4-entry FIFO and replays it as single-byte writes into a memory write port. It holds the machine in reset (`busy`) while loading, and reports byte count, a 16-bit additive checksum and an error flag on completion. It sits between the HPS download interface and the write port of one ROM instance.

---
 rtl/rom_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - host download filter, 4-entry FIFO and memory write-port replayer
//
// Takes the host download byte stream, keeps only downloads whose index
// matches INDEX, buffers bytes in a 4-entry FIFO and replays them as
// single-byte writes into one memory write port. Holds the machine in reset
// (busy) while loading and reports count / additive checksum / error at the end.
//
// Ports:
//   clock, reset           - system clock, asynchronous active-high reset
//   dl_active, dl_index    - download in progress (level), index sampled at start
//   dl_wr, dl_addr, dl_data- one-cycle byte strobe with address and data
//   dl_wait                - backpressure to host (occupancy >= 3, registered)
//   mem_a, mem_d, mem_w    - memory write address / data / request (FIFO head)
//   mem_ready              - write accepted this cycle when high with mem_w
//   busy, done, err        - loading, last load completed, sticky per-load error
//   count, sum             - bytes written (saturating), modulo-2^16 byte sum
module rom_loader #(
    parameter  int KB    = 16,
    parameter  int INDEX = 0,
    localparam int AW    = $clog2(KB * 1024)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          dl_active,
    input  logic [7:0]    dl_index,
    input  logic          dl_wr,
    input  logic [24:0]   dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_wait,
    output logic [AW-1:0] mem_a,
    output logic [7:0]    mem_d,
    output logic          mem_w,
    input  logic          mem_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count,
    output logic [15:0]   sum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_active_prev;
    logic [AW-1:0] r_fifo_a [4];
    logic [7:0]    r_fifo_d [4];
    logic [1:0]    r_wptr;
    logic [1:0]    r_rptr;
    logic [2:0]    r_occ;
    logic          r_wait;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [AW:0]   r_count;
    logic [15:0]   r_sum;

    logic          w_start;
    logic          w_pop;
    logic          w_in_range;
    logic          w_strobe;
    logic          w_push;
    logic          w_drop;
    logic [2:0]    w_occ_next;

    // A load starts only on the rising edge of dl_active, so a non-matching
    // download never re-triggers later in the same download.
    assign w_start    = dl_active && !r_active_prev && (dl_index == 8'(INDEX))
                        && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_pop      = (r_occ != 3'd0) && mem_ready;
    assign w_in_range = ({7'd0, dl_addr} < 32'(KB * 1024));
    assign w_strobe   = (r_state == S_LOAD) && dl_wr;
    // A full FIFO still accepts a byte when the head retires in the same cycle.
    assign w_push     = w_strobe && w_in_range && ((r_occ != 3'd4) || w_pop);
    assign w_drop     = w_strobe && !w_push;
    assign w_occ_next = w_start ? 3'd0
                                : r_occ + {2'd0, w_push} - {2'd0, w_pop};

    // FIFO storage needs no reset: mem_a/mem_d are masked while empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_a[r_wptr] <= dl_addr[AW-1:0];
            r_fifo_d[r_wptr] <= dl_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_active_prev <= 1'b0;
            r_wptr        <= 2'd0;
            r_rptr        <= 2'd0;
            r_occ         <= 3'd0;
            r_wait        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_count       <= '0;
            r_sum         <= 16'd0;
        end else begin
            r_active_prev <= dl_active;
            r_occ         <= w_occ_next;
            r_wait        <= (w_occ_next >= 3'd3);
            if (w_start) begin
                r_state <= S_LOAD;
                r_wptr  <= 2'd0;
                r_rptr  <= 2'd0;
                r_count <= '0;
                r_sum   <= 16'd0;
                r_err   <= 1'b0;
                r_done  <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 2'd1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 2'd1;
                    r_sum  <= r_sum + {8'd0, r_fifo_d[r_rptr]};
                    if (r_count != '1) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                if (w_drop) begin
                    r_err <= 1'b1;
                end
                case (r_state)
                    S_LOAD: begin
                        if (!dl_active) begin
                            r_state <= S_FLUSH;
                        end
                    end
                    S_FLUSH: begin
                        // Finish on the edge that retires the last entry.
                        if (w_occ_next == 3'd0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem_w   = (r_occ != 3'd0);
    assign mem_a   = mem_w ? r_fifo_a[r_rptr] : '0;
    assign mem_d   = mem_w ? r_fifo_d[r_rptr] : 8'd0;
    assign dl_wait = r_wait;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign count   = r_count;
    assign sum     = r_sum;

endmodule
